// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with a data-memory handshake, access checks and a timeout abort
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rd2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_link,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_pc_plus4,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_is_load;

  logic        w_is_mem;
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  assign stall    = (r_state == S_ACCESS);
  assign w_is_mem = ex_mem_read | ex_mem_write;

  assign w_illegal = (ex_mem_read & ex_mem_write) |
                     (w_is_mem & (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111));

  // funct3[1:0] carries the width for both signed and unsigned loads
  assign w_misaligned = w_is_mem &
                        (((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00)) ||
                         ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_rd2;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ex_alu_result[1:0];
          w_wdata = {4{ex_rd2[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << ex_alu_result[1:0];
          w_wdata = {2{ex_rd2[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_rd2;
        end
      endcase
    end
  end

  assign w_shifted = dmem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_is_load    <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (w_illegal || w_misaligned) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_result;
              err          <= 1'b1;
              err_code     <= w_illegal ? 2'b11 : 2'b01;
            end else if (w_is_mem) begin
              r_state     <= S_ACCESS;
              r_cnt       <= 8'd0;
              r_funct3    <= ex_funct3;
              r_addr_lo   <= ex_alu_result[1:0];
              r_rd        <= ex_rd;
              r_reg_write <= ex_reg_write;
              r_is_load   <= ex_mem_read;
              dmem_req    <= 1'b1;
              dmem_we     <= ex_mem_write;
              dmem_addr   <= {ex_alu_result[31:2], 2'b00};
              dmem_wdata  <= w_wdata;
              dmem_be     <= w_be;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= ex_reg_write;
              wb_rd        <= ex_rd;
              wb_data      <= ex_link ? ex_pc_plus4 : ex_alu_result;
              err_code     <= 2'b00;
            end
          end
        end
        S_ACCESS: begin
          // an ack on the timeout edge still completes the access normally
          if (dmem_ack) begin
            r_state      <= S_IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= r_is_load & r_reg_write;
            wb_rd        <= r_rd;
            wb_data      <= r_is_load ? w_load_data : 32'd0;
            err_code     <= 2'b00;
          end else if (r_cnt + 8'd1 == LP_TIMEOUT) begin
            r_state      <= S_IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= r_rd;
            wb_data      <= 32'd0;
            err          <= 1'b1;
            err_code     <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed-vector bench for mem_stage built with TIMEOUT_CYCLES=4
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_rd2 = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_link = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_pc_plus4 = '0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_rd2(ex_rd2), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_link(ex_link),
    .ex_rd(ex_rd), .ex_pc_plus4(ex_pc_plus4), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic rw, input logic lk);
    ex_valid = 1'b1; ex_alu_result = a; ex_rd2 = d; ex_funct3 = f; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_link = lk;
  endtask

  task automatic test_reset();
    step(); step();
    n_vec++; if ({stall, dmem_req, dmem_we, dmem_be} !== 7'd0) begin n_err++; $display("FAIL reset_ctl: got %b expected 0", {stall, dmem_req, dmem_we, dmem_be}); end
    n_vec++; if ({dmem_addr, dmem_wdata} !== 64'd0) begin n_err++; $display("FAIL reset_dmem: got %h expected 0", {dmem_addr, dmem_wdata}); end
    n_vec++; if ({wb_valid, wb_reg_write, wb_rd, wb_data, err, err_code} !== 41'd0) begin n_err++; $display("FAIL reset_wb: got %h expected 0", {wb_valid, wb_reg_write, wb_rd, wb_data, err, err_code}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive(32'h0000_1234, 32'd0, 3'b000, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    n_vec++; if ({wb_valid, wb_reg_write, wb_rd, stall, err} !== {1'b1, 1'b1, 5'd5, 1'b0, 1'b0}) begin n_err++; $display("FAIL alu_ctl: got %b expected 1100101_0_0", {wb_valid, wb_reg_write, wb_rd, stall, err}); end
    n_vec++; if (wb_data !== 32'h0000_1234) begin n_err++; $display("FAIL alu_data: got %h expected 00001234", wb_data); end
    step();
    n_vec++; if ({wb_valid, stall} !== 2'b00) begin n_err++; $display("FAIL alu_pulse: got %b expected 00", {wb_valid, stall}); end
  endtask

  task automatic test_link();
    ex_pc_plus4 = 32'h0000_0A04;
    drive(32'h0000_7777, 32'd0, 3'b000, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    ex_valid = 1'b0; ex_link = 1'b0;
    n_vec++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_0A04}) begin n_err++; $display("FAIL link_data: got %h expected 100000a04", {wb_valid, wb_data}); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(32'h0000_AAAA, 32'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    n_vec++; if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd0, 32'h0000_AAAA}) begin n_err++; $display("FAIL b2b_x0: got %h expected %h", {wb_valid, wb_reg_write, wb_rd, wb_data}, {1'b1, 1'b1, 5'd0, 32'h0000_AAAA}); end
    drive(32'h0000_5555, 32'd0, 3'b000, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    n_vec++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'h0000_5555}) begin n_err++; $display("FAIL b2b_second: got %h expected %h", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd3, 32'h0000_5555}); end
    step();
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b expected 0", wb_valid); end
  endtask

  task automatic test_lb();
    int stall_cycles = 0;
    drive(32'h0000_0103, 32'd0, 3'b000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    n_vec++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_0100}) begin n_err++; $display("FAIL lb_req: got %h expected %h", {dmem_req, dmem_we, dmem_be, dmem_addr}, {1'b1, 1'b0, 4'hF, 32'h0000_0100}); end
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cycles++;
      if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000; end
      step();
    end
    dmem_ack = 1'b0;
    n_vec++; if (stall_cycles !== 3) begin n_err++; $display("FAIL lb_stall_cycles: got %0d expected 3", stall_cycles); end
    n_vec++; if ({wb_valid, wb_reg_write, wb_rd, stall, dmem_req, err} !== {1'b1, 1'b1, 5'd7, 3'b000}) begin n_err++; $display("FAIL lb_wb_ctl: got %b expected 1100111000", {wb_valid, wb_reg_write, wb_rd, stall, dmem_req, err}); end
    n_vec++; if (wb_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h expected ffffff80", wb_data); end
    step();
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [3] = '{3'b001, 3'b101, 3'b100};
    logic [31:0] adr [3] = '{32'h102, 32'h102, 32'h101};
    logic [31:0] rd  [3] = '{32'h8001_0000, 32'h8001_0000, 32'h0000_9A00};
    logic [31:0] exp [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_009A};
    for (int i = 0; i < 3; i++) begin
      drive(adr[i], 32'd0, f3[i], 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      ex_valid = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = rd[i];
      step();
      dmem_ack = 1'b0;
      n_vec++; if ({wb_valid, stall, wb_data} !== {1'b1, 1'b0, exp[i]}) begin n_err++; $display("FAIL load_ext_%0d: got %h expected %h", i, {wb_valid, stall, wb_data}, {1'b1, 1'b0, exp[i]}); end
    end
    step();
  endtask

  task automatic test_sh();
    drive(32'h0000_0202, 32'h0000_ABCD, 3'b001, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    n_vec++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b1, 4'b1100, 32'h0000_0200}) begin n_err++; $display("FAIL sh_req: got %h expected %h", {dmem_req, dmem_we, dmem_be, dmem_addr}, {1'b1, 1'b1, 4'b1100, 32'h0000_0200}); end
    n_vec++; if (dmem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata: got %h expected abcdabcd", dmem_wdata); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    n_vec++; if ({wb_valid, wb_reg_write, stall, err, dmem_req} !== 5'b10000) begin n_err++; $display("FAIL sh_wb: got %b expected 10000", {wb_valid, wb_reg_write, stall, err, dmem_req}); end
    step();
  endtask

  task automatic test_sb();
    drive(32'h0000_0203, 32'h1234_5678, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    ex_valid = 1'b0;
    n_vec++; if ({dmem_be, dmem_wdata} !== {4'b1000, 32'h7878_7878}) begin n_err++; $display("FAIL sb_lane: got %h expected 878787878", {dmem_be, dmem_wdata}); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    step();
  endtask

  task automatic test_errors();
    logic [31:0] adr [4] = '{32'h101, 32'h40, 32'h41, 32'h103};
    logic [2:0]  f3  [4] = '{3'b010, 3'b010, 3'b011, 3'b101};
    logic        mr  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic        mw  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  ec  [4] = '{2'b01, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      drive(adr[i], 32'd0, f3[i], 5'd6, mr[i], mw[i], 1'b1, 1'b0);
      step();
      ex_valid = 1'b0;
      n_vec++; if ({wb_valid, wb_reg_write, err, err_code, dmem_req, stall} !== {1'b1, 1'b0, 1'b1, ec[i], 2'b00}) begin n_err++; $display("FAIL access_err_%0d: got %b expected %b", i, {wb_valid, wb_reg_write, err, err_code, dmem_req, stall}, {1'b1, 1'b0, 1'b1, ec[i], 2'b00}); end
      step();
      n_vec++; if ({wb_valid, err} !== 2'b00) begin n_err++; $display("FAIL err_pulse_%0d: got %b expected 00", i, {wb_valid, err}); end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    drive(32'h0000_0040, 32'h1111_2222, 3'b010, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 10 && dmem_req; i++) begin
      req_cycles++;
      step();
    end
    n_vec++; if (req_cycles !== 4) begin n_err++; $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles); end
    n_vec++; if ({wb_valid, wb_reg_write, err, err_code, stall, dmem_req} !== 7'b1011000) begin n_err++; $display("FAIL timeout_wb: got %b expected 1011000", {wb_valid, wb_reg_write, err, err_code, stall, dmem_req}); end
    step();
  endtask

  task automatic test_ack_on_timeout();
    drive(32'h0000_0010, 32'd0, 3'b010, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    step(); step(); step();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    n_vec++; if ({wb_valid, wb_reg_write, err, wb_data} !== {3'b110, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL ack_wins: got %h expected %h", {wb_valid, wb_reg_write, err, wb_data}, {3'b110, 32'hDEAD_BEEF}); end
    step();
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1'b1;
    step(); step();
    dmem_ack = 1'b0;
    n_vec++; if ({wb_valid, stall, dmem_req} !== 3'b000) begin n_err++; $display("FAIL idle_ack: got %b expected 000", {wb_valid, stall, dmem_req}); end
  endtask

  task automatic test_reset_mid_access();
    int wb_seen = 0;
    drive(32'h0000_0080, 32'd0, 3'b010, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({dmem_req, stall} !== 2'b00) begin n_err++; $display("FAIL rst_async: got %b expected 00", {dmem_req, stall}); end
    #1 rst = 1'b0;
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_valid) wb_seen++;
    end
    dmem_ack = 1'b0;
    n_vec++; if (wb_seen !== 0) begin n_err++; $display("FAIL rst_discard: got %0d writebacks expected 0", wb_seen); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_link();
    test_back_to_back();
    test_lb();
    test_load_ext();
    test_sh();
    test_sb();
    test_errors();
    test_timeout();
    test_ack_on_timeout();
    test_idle_ack();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of sequence expected completion");
    $fatal(1);
  end

endmodule
